// File: rtl/lcd_source_arbiter_if.sv
// Bundle between the LCD timing/pixel sources and lcd_source_arbiter.
// The master side drives positions, pixels, liveness and selection; the
// slave (arbiter) side returns the selected pixel and arbitration status.
interface lcd_source_arbiter_if #(
    parameter int NUM_SRC = 2,
    parameter int PIX_W   = 2,
    parameter int XW      = 9,
    parameter int YW      = 8,
    parameter int SELW    = 3
);
    logic [XW-1:0]            lcd_xpos;
    logic [YW-1:0]            lcd_ypos;
    logic [NUM_SRC*PIX_W-1:0] src_data;
    logic [NUM_SRC-1:0]       src_alive;
    logic [SELW-1:0]          sel_req;
    logic                     sel_req_valid;
    logic [PIX_W-1:0]         out_data;
    logic [SELW-1:0]          active_src;
    logic                     switch_pending;
    logic [NUM_SRC-1:0]       src_dead;

    modport master (
        output lcd_xpos, lcd_ypos, src_data, src_alive, sel_req, sel_req_valid,
        input  out_data, active_src, switch_pending, src_dead
    );

    modport slave (
        input  lcd_xpos, lcd_ypos, src_data, src_alive, sel_req, sel_req_valid,
        output out_data, active_src, switch_pending, src_dead
    );
endinterface

// File: rtl/lcd_source_arbiter.sv
// lcd_source_arbiter: frame-aligned N-input pixel source selector for the
// LCD controller. Tracks per-source liveness, falls back to the lowest live
// source when the preferred one dies, and returns when it recovers.
// Source switches only happen at frame start so the panel never sees a torn
// frame.
// Optional: define LCD_SOURCE_ARBITER_TESTPAT_EN to add a test_pat input that
// forces a checkerboard onto out_data (not frame-aligned).
module lcd_source_arbiter #(
    parameter int                 NUM_SRC        = 2,
    parameter int                 PIX_W          = 2,
    parameter int                 XW             = 9,
    parameter int                 YW             = 8,
    parameter int                 SELW           = 3,
    parameter int                 TIMEOUT_FRAMES = 8,
    parameter logic [NUM_SRC-1:0] ALWAYS_ALIVE   = NUM_SRC'(1)
) (
    input  logic clk_8m,
    input  logic rst,
`ifdef LCD_SOURCE_ARBITER_TESTPAT_EN
    input  logic test_pat,
`endif
    lcd_source_arbiter_if.slave bus
);
    localparam int            NSEL      = 2 ** SELW;
    localparam int            PW        = XW + YW;
    localparam logic [7:0]    TO_MAX    = 8'(TIMEOUT_FRAMES);
    localparam logic [SELW:0] NUM_SRC_L = (SELW + 1)'(NUM_SRC);

    logic [PW-1:0]    pos_s;
    logic [PW-1:0]    prev_pos_r;
    logic             fs_s;
    logic [7:0]       cnt_r [NUM_SRC];
    logic [NUM_SRC-1:0] dead_s;
    logic [NSEL-1:0]  dead_pad_s;
    logic [SELW-1:0]  pref_r;
    logic [SELW-1:0]  active_r;
    logic [SELW-1:0]  fallback_s;
    logic             found_s;
    logic [SELW-1:0]  target_s;
    logic [PIX_W-1:0] src_pix_s [NSEL];
    logic [PIX_W-1:0] out_data_r;

    // Frame start: first (0,0) after a nonzero position. prev_pos_r resets to
    // all-ones so the first (0,0) after reset counts as a frame start.
    assign pos_s = {bus.lcd_ypos, bus.lcd_xpos};
    assign fs_s  = (pos_s == '0) && (prev_pos_r != '0);

    // Previous-position register for frame start detection.
    always_ff @(posedge clk_8m) begin
        if (rst) begin
            prev_pos_r <= '1;
        end else begin
            prev_pos_r <= pos_s;
        end
    end

    // Per-source liveness counters: alive pulse clears (wins over fs), fs
    // counts up and saturates at the timeout. Reset starts them saturated so
    // sources must prove themselves alive first.
    always_ff @(posedge clk_8m) begin
        for (int i = 0; i < NUM_SRC; i++) begin
            if (rst) begin
                cnt_r[i] <= TO_MAX;
            end else if (bus.src_alive[i]) begin
                cnt_r[i] <= 8'd0;
            end else if (fs_s && (cnt_r[i] != TO_MAX)) begin
                cnt_r[i] <= cnt_r[i] + 8'd1;
            end else begin
                cnt_r[i] <= cnt_r[i];
            end
        end
    end

    // Dead flags, padded with ones up to the full index range so an index
    // beyond NUM_SRC can never be treated as a live source.
    always_comb begin
        dead_s     = '0;
        dead_pad_s = '1;
        for (int i = 0; i < NUM_SRC; i++) begin
            dead_s[i] = (cnt_r[i] == TO_MAX) && !ALWAYS_ALIVE[i];
        end
        dead_pad_s[NUM_SRC-1:0] = dead_s;
    end

    // Preference register: sticky, only updated by in-range requests.
    always_ff @(posedge clk_8m) begin
        if (rst) begin
            pref_r <= '0;
        end else if (bus.sel_req_valid && ({1'b0, bus.sel_req} < NUM_SRC_L)) begin
            pref_r <= bus.sel_req;
        end else begin
            pref_r <= pref_r;
        end
    end

    // Target selection: preferred source if live, else lowest live index,
    // else source 0.
    always_comb begin
        fallback_s = '0;
        found_s    = 1'b0;
        for (int j = 0; j < NUM_SRC; j++) begin
            fallback_s = (!found_s && !dead_s[j]) ? SELW'(j) : fallback_s;
            found_s    = found_s | !dead_s[j];
        end
        target_s = dead_pad_s[pref_r] ? fallback_s : pref_r;
    end

    // Active source register: only moves at frame start.
    always_ff @(posedge clk_8m) begin
        if (rst) begin
            active_r <= '0;
        end else if (fs_s) begin
            active_r <= target_s;
        end else begin
            active_r <= active_r;
        end
    end

    // Unpack source pixels into an index-width array; unused slots read zero.
    always_comb begin
        for (int k = 0; k < NSEL; k++) begin
            src_pix_s[k] = '0;
        end
        for (int k = 0; k < NUM_SRC; k++) begin
            src_pix_s[k] = bus.src_data[k*PIX_W +: PIX_W];
        end
    end

`ifdef LCD_SOURCE_ARBITER_TESTPAT_EN
    logic [1:0]       chk_s;
    logic [PIX_W-1:0] chk_pix_s;
    assign chk_s     = bus.lcd_xpos[4:3] ^ bus.lcd_ypos[4:3];
    assign chk_pix_s = PIX_W'(chk_s);

    // Output pixel register; test pattern overrides the sources immediately,
    // arbitration keeps running underneath.
    always_ff @(posedge clk_8m) begin
        if (rst) begin
            out_data_r <= '0;
        end else if (test_pat) begin
            out_data_r <= chk_pix_s;
        end else begin
            out_data_r <= src_pix_s[active_r];
        end
    end
`else
    // Output pixel register; uses the pre-edge active source, so on a frame
    // start edge the old source is still emitted for that cycle.
    always_ff @(posedge clk_8m) begin
        if (rst) begin
            out_data_r <= '0;
        end else begin
            out_data_r <= src_pix_s[active_r];
        end
    end
`endif

    assign bus.out_data       = out_data_r;
    assign bus.active_src     = active_r;
    assign bus.switch_pending = (target_s != active_r);
    assign bus.src_dead       = dead_s;
endmodule
